// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multi-cycle MIPS main control.
// Opcodes, state encodings, ALUop codes, alu_src_b and pc_source selects.
// Build option MC_ADDI_EN adds the ADDI_EX / ADDI_WB states.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC     = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
`ifdef MC_ADDI_EN
    ST_JUMP     = 4'd9,
    ST_ADDI_EX  = 4'd10,
    ST_ADDI_WB  = 4'd11
`else
    ST_JUMP     = 4'd9
`endif
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold until the memory signals mem_ready.
  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational control decode for the main control FSM.
// Inputs : state (current state), opcode (IR[31:26]), mem_ready.
// Outputs: every datapath enable/select, illegal_op, next_state.
// Build option MC_ADDI_EN decodes opcode 001000 into ADDI_EX/ADDI_WB;
// without it that opcode is reported as illegal.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       illegal_op,
  output logic [3:0] next_state
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_op        = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    illegal_op    = 1'b0;
    next_state    = ST_FETCH;

    case (state)
      ST_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        next_state = mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE:     next_state = ST_EXEC;
          OP_LW, OP_SW: next_state = ST_MEM_ADDR;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_J:         next_state = ST_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      next_state = ST_ADDI_EX;
`endif
          default:      illegal_op = 1'b1;
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        next_state = mem_ready ? ST_MEM_WB : ST_MEM_RD;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        next_state = mem_ready ? ST_FETCH : ST_MEM_WR;
      end
      ST_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        next_state = ST_R_WB;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
`ifdef MC_ADDI_EN
      ST_ADDI_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        reg_write = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM (fetch, decode,
// execute, memory, writeback) driving datapath enables and mux selects.
// Holds the state register and the 8-bit memory wait timeout counter;
// decode of outputs/next state lives in mc_ctrl_decode.
// Ports: clk, rst_n (async active-low), opcode, mem_ready in;
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
//   ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
//   illegal_op, mem_timeout, state out.
// Parameter MEM_TIMEOUT: wait cycles before abort, 0 disables (0..255).
// Build option MC_ADDI_EN enables the ADDI states 10/11.
//
// state | meaning
// ------+---------------------------------------------
//   0   | FETCH    read instruction, PC+4 (wait state)
//   1   | DECODE   register read, branch target calc
//   2   | MEM_ADDR effective address for lw/sw
//   3   | MEM_RD   data read (wait state)
//   4   | MEM_WB   write MDR to rt
//   5   | MEM_WR   data write (wait state)
//   6   | EXEC     R-type ALU operation
//   7   | R_WB     write ALUOut to rd
//   8   | BRANCH   beq compare and conditional PC load
//   9   | JUMP     PC load from jump target
//  10   | ADDI_EX  immediate add (MC_ADDI_EN only)
//  11   | ADDI_WB  write ALUOut to rt (MC_ADDI_EN only)
module mc_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam bit         TO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [3:0] state_q;
  logic [3:0] dec_next;
  logic [7:0] wait_cnt;
  logic       in_wait;
  logic       timeout_hit;
  logic       d_pc_write, d_pc_write_cond, d_mem_read, d_mem_write;
  logic       d_ir_write, d_reg_write, d_illegal_op;

  mc_ctrl_decode u_decode (
    .state        (state_q),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (d_pc_write),
    .pc_write_cond(d_pc_write_cond),
    .i_or_d       (i_or_d),
    .mem_read     (d_mem_read),
    .mem_write    (d_mem_write),
    .mem_to_reg   (mem_to_reg),
    .ir_write     (d_ir_write),
    .pc_source    (pc_source),
    .alu_op       (alu_op),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .reg_write    (d_reg_write),
    .reg_dst      (reg_dst),
    .illegal_op   (d_illegal_op),
    .next_state   (dec_next)
  );

  assign in_wait     = is_wait_state(state_q);
  // mem_ready wins over the timeout in the same cycle.
  assign timeout_hit = TO_EN && in_wait && !mem_ready && (wait_cnt == TO_LAST);

  // State resets to FETCH, which would request a read; gating with rst_n
  // keeps every enable quiet for as long as reset is held.
  assign pc_write      = d_pc_write      & rst_n;
  assign pc_write_cond = d_pc_write_cond & rst_n;
  assign mem_read      = d_mem_read      & rst_n;
  assign mem_write     = d_mem_write     & rst_n;
  assign ir_write      = d_ir_write      & rst_n;
  assign reg_write     = d_reg_write     & rst_n;
  assign illegal_op    = d_illegal_op    & rst_n;
  assign mem_timeout   = timeout_hit     & rst_n;
  assign state         = state_q;

  // Counter runs only while stalled in a wait state; any transition
  // (entering, leaving or aborting) clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state_q  <= timeout_hit ? ST_FETCH : dec_next;
      wait_cnt <= (in_wait && !mem_ready && !timeout_hit) ? wait_cnt + 8'd1 : 8'd0;
    end
  end

endmodule

// File: tb/tb_mc_main_control.sv
module tb_mc_main_control;

  localparam int TO = 4;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       ir_write, alu_src_a, reg_write, reg_dst, illegal_op, mem_timeout;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_main_control #(.MEM_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .ir_write     (ir_write),
    .pc_source    (pc_source),
    .alu_op       (alu_op),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .illegal_op   (illegal_op),
    .mem_timeout  (mem_timeout),
    .state        (state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: current spec state number, stall count, and the list
  // of states still to visit for the instruction being executed.
  int ms;
  int mcnt;
  int plan[$];

  function automatic bit is_wait(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic bit known_op(input logic [5:0] op);
    bit k;
    k = (op == T_R) || (op == T_LW) || (op == T_SW) || (op == T_BEQ) || (op == T_J);
`ifdef MC_ADDI_EN
    k = k || (op == T_ADDI);
`endif
    return k;
  endfunction

  task automatic make_plan(input logic [5:0] op);
    plan.delete();
    if (op == T_LW)       plan = '{2, 3, 4};
    else if (op == T_SW)  plan = '{2, 5};
    else if (op == T_R)   plan = '{6, 7};
    else if (op == T_BEQ) plan = '{8};
    else if (op == T_J)   plan = '{9};
`ifdef MC_ADDI_EN
    else if (op == T_ADDI) plan = '{10, 11};
`endif
  endtask

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
  //  ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst}
  function automatic logic [16:0] exp_vec(input int s, input logic rdy);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd;
    logic [1:0] pcs, aop, asb;
    pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; m2r = 0; irw = 0;
    asa = 0; rw = 0; rd = 0; pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, asa, asb, rw, rd};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
            ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst};
  endfunction

  // One clock: drive at the falling edge, check outputs, advance the model.
  task automatic step(input logic [5:0] op, input logic rdy);
    bit to_exp;
    @(negedge clk);
    rst_n     = 1'b1;
    opcode    = op;
    mem_ready = rdy;
    #1;
    to_exp = is_wait(ms) && !rdy && (mcnt == TO - 1);
    check_val("state", 32'(state), 32'(ms));
    check_val("ctrl", 32'(obs_vec()), 32'(exp_vec(ms, rdy)));
    check_val("illegal_op", 32'(illegal_op), 32'((ms == 1) && !known_op(op)));
    check_val("mem_timeout", 32'(mem_timeout), 32'(to_exp));
    if (is_wait(ms) && !rdy) begin
      if (to_exp) begin
        ms = 0; mcnt = 0; plan.delete();
      end else begin
        mcnt++;
      end
    end else begin
      mcnt = 0;
      if (ms == 0) ms = 1;
      else begin
        if (ms == 1) make_plan(op);
        ms = (plan.size() > 0) ? plan.pop_front() : 0;
      end
    end
  endtask

  task automatic run_op(input logic [5:0] op, input int n);
    for (int i = 0; i < n; i++) step(op, 1'b1);
  endtask

  logic [5:0] cur_op;
  logic       rnd_rdy;

  initial begin
    ms = 0; mcnt = 0;
    rst_n = 1'b0; opcode = T_LW; mem_ready = 1'b1;
    #1;
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_enables", 32'({pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write}), 32'd0);
    repeat (2) @(posedge clk);

    // Release; ir_write must follow mem_ready in the first FETCH.
    step(T_LW, 1'b1);
    check_val("ir_write_after_rst", 32'(ir_write), 32'd1);
    run_op(T_LW, 4);
    run_op(T_R, 4);
    run_op(T_BEQ, 3);
    run_op(T_J, 3);

    // Reset asserted in the middle of a stalled MEM_RD.
    run_op(T_LW, 3);
    step(T_LW, 1'b0);
    check_val("pre_rst_state", 32'(state), 32'd3);
    #2;
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    check_val("midrst_state", 32'(state), 32'd0);
    check_val("midrst_enables", 32'({pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write}), 32'd0);
    check_val("midrst_pulses", 32'({illegal_op, mem_timeout}), 32'd0);
    ms = 0; mcnt = 0; plan.delete();
    step(T_SW, 1'b1);

    // sw stalled three cycles in MEM_WR.
    run_op(T_SW, 2);
    repeat (3) step(T_SW, 1'b0);
    step(T_SW, 1'b1);
    step(T_SW, 1'b1);

    // Timeout in MEM_RD, then mem_ready winning on the deciding cycle.
    run_op(T_LW, 3);
    repeat (3) step(T_LW, 1'b0);
    step(T_LW, 1'b0);
    step(T_LW, 1'b1);
    run_op(T_LW, 2);
    repeat (3) step(T_LW, 1'b0);
    step(T_LW, 1'b1);
    step(T_LW, 1'b1);

    // Timeout in FETCH.
    repeat (4) step(T_R, 1'b0);
    step(T_R, 1'b1);

    // ADDI (legal or illegal depending on build) and a plainly illegal op.
    run_op(T_ADDI, 5);
    run_op(6'b111111, 3);

    // Randomized run; opcode only changes while the model sits in FETCH.
    cur_op = T_R;
    for (int i = 0; i < 3000; i++) begin
      if (ms == 0) begin
        case ($urandom_range(0, 7))
          0: cur_op = T_R;
          1: cur_op = T_LW;
          2: cur_op = T_SW;
          3: cur_op = T_BEQ;
          4: cur_op = T_J;
          5: cur_op = T_ADDI;
          default: cur_op = 6'($urandom);
        endcase
      end
      if (i < 1500) rnd_rdy = ($urandom_range(0, 3) != 0);
      else          rnd_rdy = 1'($urandom_range(0, 1));
      step(cur_op, rnd_rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle MIPS main control FSM; producer side of the 2-bit ALUop interface consumed by the ALU function decoder.
- Sequences fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select.
- Waits on a memory ready handshake, with an optional timeout.
- Sits between the instruction register (opcode), the memory interface (mem_ready) and the datapath.

Parameters:
- MEM_TIMEOUT, 0, max wait-state cycles without mem_ready before abort; 0 = disabled; legal 0..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_to_reg  out  1  writeback source is MDR
- ir_write  out  1  IR load
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
- alu_op  out  2  00 add, 01 sub, 10 use funct
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- reg_write  out  1  register file write
- reg_dst  out  1  0 rt, 1 rd
- illegal_op  out  1  one-cycle pulse, unsupported opcode in DECODE
- mem_timeout  out  1  one-cycle pulse on wait abort
- state  out  4  current state, debug

Behaviour:
- 4-bit state register; async reset to FETCH (0) and clears the timeout counter.
- While rst_n = 0, all enables (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) are 0 and pulses are 0.
- Outputs are combinational from state, opcode and mem_ready. Any output not listed for a state is 0.
- States, outputs and next state:
  - 0 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. mem_ready ? DECODE : FETCH.
  - 1 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - other -> FETCH with illegal_op=1
  - 2 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_RD, sw -> MEM_WR.
  - 3 MEM_RD: mem_read=1, i_or_d=1. mem_ready -> MEM_WB.
  - 4 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
  - 5 MEM_WR: mem_write=1, i_or_d=1. mem_ready -> FETCH.
  - 6 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
  - 7 R_WB: reg_write=1, reg_dst=1 -> FETCH.
  - 8 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
  - 9 JUMP: pc_write=1, pc_source=10 -> FETCH.
- Wait states are FETCH, MEM_RD and MEM_WR. mem_ready in any other state is ignored.
- Cycle counts: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, each counted with mem_ready=1 on first request.
- Timeout counter (8-bit):
  - Cleared on entering a wait state and on leaving one.
  - Increments each wait cycle with mem_ready=0.
  - If MEM_TIMEOUT>0, counter==MEM_TIMEOUT-1 and mem_ready=0: mem_timeout=1 that cycle, next state FETCH, counter cleared.
  - mem_ready=1 in the same cycle takes priority over timeout.
- Reset mid-operation: immediate return to FETCH. Any in-flight memory access is abandoned; no enable glitches out of reset.
- Unused encodings 10..15 (12..15 with ADDI_EN): next state FETCH, all outputs 0.

Optional Feature:
- Macro MC_ADDI_EN.
- Defined: opcode 001000 in DECODE -> 10 ADDI_EX (alu_src_a=1, alu_src_b=10, alu_op=00) -> 11 ADDI_WB (reg_write=1, reg_dst=0, mem_to_reg=0) -> FETCH.
- Undefined: 001000 is illegal (illegal_op pulse, return to FETCH); states 10/11 do not exist.

Decomposition:
- Package mc_ctrl_pkg: opcode constants, state encodings, ALUop codes (ADD/SUB/FUNCT), alu_src_b and pc_source codes.
- One sub-module mc_ctrl_decode: pure combinational state+opcode+mem_ready -> control outputs and next state. The top keeps the state register and timeout counter.

Test Plan:
- Reset: rst_n=0 mid-MEM_RD -> state=0 and all enables 0 immediately. After release with mem_ready=1, ir_write=1 in the first cycle.
- lw, mem_ready always 1: opcode 100011 -> states 0,1,2,3,4; alu_op 00 throughout; reg_write and mem_to_reg =1 only in state 4.
- R-type and beq: opcode 000000 -> alu_op=10 in EXEC and reg_dst=1 in R_WB. Opcode 000100 -> alu_op=01, pc_write_cond=1, pc_source=01 in BRANCH.
- Memory stall: sw with mem_ready=0 for 3 cycles in MEM_WR -> state holds at 5 with mem_write=1; FETCH on the cycle after mem_ready=1.
- Timeout: MEM_TIMEOUT=4, mem_ready=0 in MEM_RD -> mem_timeout pulse on the 4th cycle in state 3, then state 0. mem_ready=1 on that same cycle -> MEM_WB, no pulse.
- Illegal/ADDI: opcode 001000 without MC_ADDI_EN -> illegal_op=1 in DECODE, then FETCH. With MC_ADDI_EN -> states 10, 11, with reg_write=1 and reg_dst=0 in 11.
